// File: rtl/bus_rbtr_rr_bp.sv
// Single-bus arbiter/router: grants one pending source FIFO, pops its head packet and
// pushes it to the decoded destination (or broadcast), honouring destination backpressure.
module bus_rbtr_rr_bp #(
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter int unsigned     id_w      = 8,
    parameter logic [id_w-1:0] broadcast = '1,
    parameter int unsigned     cnt_w     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    input  logic [drvrs-1:0]         full,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic                     busy,
    output logic [id_w-1:0]          src_id,
    output logic [cnt_w-1:0]         drop_cnt
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state_q, state_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [pckg_sz-1:0] dpush_q, dpush_d;
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic [id_w-1:0]    src_q, src_d;
    logic [id_w-1:0]    ptr_q, ptr_d;
    logic [cnt_w-1:0]   drop_q, drop_d;

    logic               found;
    logic [id_w-1:0]    win;
    logic [pckg_sz-1:0] win_pkt;
    logic [id_w-1:0]    dest;
    logic [drvrs-1:0]   targets;
    logic               is_drop;

    // Round-robin is two ascending passes: indices above the pointer, then the wrap-around part.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_pkt = '0;
        if (mode) begin
            for (int unsigned i = 0; i < drvrs; i++) begin
                if (!found && pndng[i]) begin
                    found   = 1'b1;
                    win     = id_w'(i);
                    win_pkt = D_pop[i*pckg_sz +: pckg_sz];
                end
            end
        end else begin
            for (int unsigned i = 0; i < drvrs; i++) begin
                if (!found && pndng[i] && (id_w'(i) > ptr_q)) begin
                    found   = 1'b1;
                    win     = id_w'(i);
                    win_pkt = D_pop[i*pckg_sz +: pckg_sz];
                end
            end
            for (int unsigned i = 0; i < drvrs; i++) begin
                if (!found && pndng[i] && (id_w'(i) <= ptr_q)) begin
                    found   = 1'b1;
                    win     = id_w'(i);
                    win_pkt = D_pop[i*pckg_sz +: pckg_sz];
                end
            end
        end
    end

    assign dest = pkt_q[pckg_sz-1 -: id_w];

    always_comb begin
        targets = '0;
        is_drop = 1'b0;
        if (dest == broadcast) begin
            for (int unsigned i = 0; i < drvrs; i++) targets[i] = (id_w'(i) != src_q);
        end else if ((dest < id_w'(drvrs)) && (dest != src_q)) begin
            for (int unsigned i = 0; i < drvrs; i++) targets[i] = (dest == id_w'(i));
        end else begin
            is_drop = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        dpush_d = dpush_q;
        pop_d   = '0;
        push_d  = '0;
        src_d   = src_q;
        ptr_d   = ptr_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    pkt_d   = win_pkt;
                    src_d   = win;
                    ptr_d   = win;
                    state_d = XFER;
                    for (int unsigned i = 0; i < drvrs; i++) pop_d[i] = (win == id_w'(i));
                end
            end
            XFER: begin
                if (is_drop) begin
                    if (drop_q != '1) drop_d = drop_q + 1'b1;
                    state_d = IDLE;
                end else if ((full & targets) == '0) begin
                    push_d  = targets;
                    dpush_d = pkt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            dpush_q <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            src_q   <= '0;
            ptr_q   <= id_w'(drvrs - 1);
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            dpush_q <= dpush_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            drop_q  <= drop_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = dpush_q;
    assign busy     = (state_q == XFER);
    assign src_id   = src_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_rbtr_rr_bp.sv
// Directed bench for bus_rbtr_rr_bp: reset, unicast, broadcast, fairness, backpressure, drops.
module tb_bus_rbtr_rr_bp;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [3:0]  pndng;
    logic [63:0] D_pop;
    logic [3:0]  pop;
    logic [3:0]  full;
    logic [3:0]  push;
    logic [15:0] D_push;
    logic        busy;
    logic [7:0]  src_id;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    bus_rbtr_rr_bp #(
        .drvrs(4), .pckg_sz(16), .id_w(8), .broadcast(8'hFF), .cnt_w(16)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .full(full), .push(push), .D_push(D_push), .busy(busy),
        .src_id(src_id), .drop_cnt(drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic load_ring();
        D_pop[0*16 +: 16] = 16'h0100;
        D_pop[1*16 +: 16] = 16'h0211;
        D_pop[2*16 +: 16] = 16'h0322;
        D_pop[3*16 +: 16] = 16'h0033;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; mode = 1'b0; full = '0; pndng = 4'hF;
        load_ring();
        repeat (3) @(negedge clk);
        total++; if (pop !== 4'b0000) begin bad++; $display("FAIL rst_pop got=%b want=0000", pop); end
        total++; if (push !== 4'b0000) begin bad++; $display("FAIL rst_push got=%b want=0000", push); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", drop_cnt); end
        total++; if (D_push !== 16'h0000) begin bad++; $display("FAIL rst_dpush got=%h want=0000", D_push); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (pop !== 4'b0001) begin bad++; $display("FAIL rst_first_rr got=%b want=0001", pop); end
        total++; if (src_id !== 8'd0) begin bad++; $display("FAIL rst_src got=%0d want=0", src_id); end
        pndng = 4'h0;
        @(negedge clk);
        total++; if (push !== 4'b0010) begin bad++; $display("FAIL rst_first_push got=%b want=0010", push); end
        // same check with fixed priority
        reset = 1'b0; mode = 1'b1; pndng = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (pop !== 4'b0001) begin bad++; $display("FAIL rst_first_fp got=%b want=0001", pop); end
        pndng = 4'h0; mode = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unicast();
        pndng = 4'b0010; D_pop[1*16 +: 16] = 16'h02AB;
        @(negedge clk);
        total++; if (pop !== 4'b0010) begin bad++; $display("FAIL uni_pop got=%b want=0010", pop); end
        total++; if (src_id !== 8'd1) begin bad++; $display("FAIL uni_src got=%0d want=1", src_id); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL uni_busy got=%b want=1", busy); end
        pndng = 4'b0000;
        @(negedge clk);
        total++; if (push !== 4'b0100) begin bad++; $display("FAIL uni_push got=%b want=0100", push); end
        total++; if (D_push !== 16'h02AB) begin bad++; $display("FAIL uni_data got=%h want=02AB", D_push); end
        total++; if (pop !== 4'b0000) begin bad++; $display("FAIL uni_pop_once got=%b want=0000", pop); end
        @(negedge clk);
        total++; if (push !== 4'b0000) begin bad++; $display("FAIL uni_push_once got=%b want=0000", push); end
        total++; if (D_push !== 16'h02AB) begin bad++; $display("FAIL uni_hold got=%h want=02AB", D_push); end
    endtask

    task automatic test_broadcast();
        pndng = 4'b0100; D_pop[2*16 +: 16] = 16'hFF55;
        @(negedge clk);
        total++; if (pop !== 4'b0100) begin bad++; $display("FAIL bc_pop got=%b want=0100", pop); end
        pndng = 4'b0000;
        @(negedge clk);
        total++; if (push !== 4'b1011) begin bad++; $display("FAIL bc_push got=%b want=1011", push); end
        total++; if (D_push !== 16'hFF55) begin bad++; $display("FAIL bc_data got=%h want=FF55", D_push); end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0] exp_pop;
        logic [3:0] exp_push;
        reset = 1'b0; mode = 1'b0; full = '0;
        load_ring();
        pndng = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_pop  = 4'b0001 << exp_order[k];
            exp_push = 4'b0001 << ((exp_order[k] + 1) % 4);
            @(negedge clk);
            total++; if (pop !== exp_pop) begin bad++; $display("FAIL rr_pop[%0d] got=%b want=%b", k, pop, exp_pop); end
            @(negedge clk);
            total++; if (push !== exp_push) begin bad++; $display("FAIL rr_push[%0d] got=%b want=%b", k, push, exp_push); end
        end
        mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (pop !== 4'b0001) begin bad++; $display("FAIL fp_pop[%0d] got=%b want=0001", k, pop); end
            @(negedge clk);
            total++; if (push !== 4'b0010) begin bad++; $display("FAIL fp_push[%0d] got=%b want=0010", k, push); end
        end
        pndng = 4'h0; mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        D_pop[0*16 +: 16] = 16'h0311; pndng = 4'b0001; full = 4'b1000;
        @(negedge clk);
        total++; if (pop !== 4'b0001) begin bad++; $display("FAIL bp_pop got=%b want=0001", pop); end
        pndng = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (push !== 4'b0000) begin bad++; $display("FAIL bp_stall_push[%0d] got=%b want=0000", k, push); end
            total++; if (pop !== 4'b0000) begin bad++; $display("FAIL bp_stall_pop[%0d] got=%b want=0000", k, pop); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d] got=%b want=1", k, busy); end
        end
        full = 4'b0000;
        @(negedge clk);
        total++; if (push !== 4'b1000) begin bad++; $display("FAIL bp_push got=%b want=1000", push); end
        total++; if (D_push !== 16'h0311) begin bad++; $display("FAIL bp_data got=%h want=0311", D_push); end
        @(negedge clk);
    endtask

    task automatic test_drops();
        logic [15:0] pkts[2] = '{16'h0722, 16'h0100};
        for (int k = 0; k < 2; k++) begin
            D_pop[1*16 +: 16] = pkts[k]; pndng = 4'b0010;
            @(negedge clk);
            total++; if (pop !== 4'b0010) begin bad++; $display("FAIL drop_pop[%0d] got=%b want=0010", k, pop); end
            pndng = 4'b0000;
            @(negedge clk);
            total++; if (push !== 4'b0000) begin bad++; $display("FAIL drop_push[%0d] got=%b want=0000", k, push); end
            total++; if (drop_cnt !== 16'(k + 1)) begin bad++; $display("FAIL drop_cnt[%0d] got=%0d want=%0d", k, drop_cnt, k + 1); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle[%0d] got=%b want=0", k, busy); end
            total++; if (D_push !== 16'h0311) begin bad++; $display("FAIL drop_hold[%0d] got=%h want=0311", k, D_push); end
        end
    endtask

    task automatic test_reset_midxfer();
        D_pop[0*16 +: 16] = 16'h0311; pndng = 4'b0001; full = 4'b1000;
        @(negedge clk);
        pndng = 4'b0000;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_stalled got=%b want=1", busy); end
        #2 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL mid_drop got=%0d want=0", drop_cnt); end
        total++; if (D_push !== 16'h0000) begin bad++; $display("FAIL mid_dpush got=%h want=0000", D_push); end
        total++; if (src_id !== 8'd0) begin bad++; $display("FAIL mid_src got=%0d want=0", src_id); end
        @(negedge clk);
        full = 4'b0000;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (push !== 4'b0000) begin bad++; $display("FAIL mid_nopush[%0d] got=%b want=0000", k, push); end
        end
    endtask

    initial begin
        reset = 1'b0; mode = 1'b0; pndng = '0; full = '0; D_pop = '0;
        test_reset();
        test_unicast();
        test_broadcast();
        test_fairness();
        test_backpressure();
        test_drops();
        test_reset_midxfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_rbtr_rr_bp.md
Name: bus_rbtr_rr_bp

Overview:
- Next-generation single-bus arbiter and packet router for the `drvrs`-device bus.
- Each device exposes a FIFO head: `pndng`, `D_pop` and `pop`. The block grants one source and pops its head packet.
- It decodes the destination ID field and pushes the packet to one device, or to all devices except the source (broadcast).
- Additions over the current generation: selectable round-robin/fixed-priority arbitration, per-destination full backpressure, invalid/self-address drop with a counter, and a last-source report.

Parameters:
- drvrs, 4, number of devices on the bus (2..2^id_w-1).
- pckg_sz, 16, packet width in bits; destination ID is the top id_w bits.
- id_w, 8, destination ID field width (id_w < pckg_sz).
- broadcast, {id_w{1'b1}} (8'hFF), ID meaning "all devices except source".
- cnt_w, 16, drop counter width.

Ports:
- clk  in  1  bus clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- pndng  in  drvrs  device i FIFO non-empty; head data valid on D_pop slice i.
- D_pop  in  drvrs*pckg_sz  flattened head packets; slice i = [i*pckg_sz +: pckg_sz].
- pop  out  drvrs  one-cycle pop strobe to source FIFO.
- full  in  drvrs  destination i cannot accept a push.
- push  out  drvrs  one-cycle push strobe(s) to destination FIFO(s).
- D_push  out  pckg_sz  shared bus data, valid while any push bit is high.
- busy  out  1  high whenever state != IDLE.
- src_id  out  id_w  index of the most recently granted source.
- drop_cnt  out  cnt_w  saturating count of dropped packets.

Behaviour:
- Reset (reset = 0, async): state = IDLE; pop, push, D_push, src_id, drop_cnt = 0; internal packet register = 0; RR pointer = drvrs-1, so device 0 wins first.
- All outputs are registered. Reset asserted mid-transfer discards the held packet. No push is issued after reset deasserts.
- FSM has two states, IDLE and XFER.
- IDLE:
  - If pndng == 0: stay in IDLE; pop = 0 and push = 0.
  - Otherwise, at the edge: select winner w; latch pkt = D_pop[w]; set pop = onehot(w) for exactly one cycle; src_id = w; RR pointer = w; go to XFER.
- Arbitration:
  - mode 0: first set pndng bit searching from pointer+1 upward, wrapping at drvrs-1 -> 0.
  - mode 1: lowest set index.
  - mode is sampled only at the grant edge. The pointer updates in both modes.
- XFER: decode dest = pkt[pckg_sz-1 -: id_w]. Target set:
  - dest == broadcast: all i != src_id.
  - dest < drvrs and dest != src_id: onehot(dest).
  - Otherwise (out of range, or self-address): drop. drop_cnt += 1, saturating at all-ones. No push. Go to IDLE at the next edge.
- XFER, non-drop case:
  - If (full & targets) != 0: stall. Stay in XFER; push = 0; pop stays 0; pkt is held.
  - Broadcast waits until every target is not full; no partial delivery.
  - Once clear: at the edge, push = targets for one cycle, D_push = pkt, go to IDLE.
- D_push holds its last value until the next transfer.
- Latency: pndng seen at edge N -> pop high N..N+1 -> push high N+1..N+2 when unstalled. Peak throughput is one packet per 2 cycles.
- pop is never asserted twice for one packet. pop and push are never high in the same cycle.
- pndng changes during XFER are ignored. full is only evaluated in XFER.

Test Plan:
- Reset: hold reset = 0 with all pndng = 1 -> pop = push = 0, busy = 0, drop_cnt = 0. After release, first grant is device 0 in both modes.
- Unicast: pndng = 4'b0010, D_pop[1] = 16'h02AB -> pop = 4'b0010 for one cycle, then push = 4'b0100 with D_push = 16'h02AB, src_id = 1.
- Broadcast: pndng = 4'b0100, D_pop[2] = 16'hFF55 -> pop = 4'b0100, then push = 4'b1011, D_push = 16'hFF55.
- Fairness, all pndng held high with valid dests:
  - mode 0 -> grant order 0,1,2,3,0,1 at one grant per 2 cycles.
  - Switch to mode 1 -> grants always 0.
- Backpressure: packet 16'h0311 from device 0 with full[3] = 1 for 5 cycles -> busy high, push = 0 for those 5 cycles, single pop only. push = 4'b1000 one cycle after full[3] falls.
- Drops and reset:
  - dest 8'h07 and self-address 16'h0100 from device 1 -> drop_cnt increments by 1 each, no push.
  - Assert reset during a stalled XFER -> outputs clear immediately; no push after release.
